// File: rtl/vx_csr_writeback.sv
// Commit sink for the CSR unit: buffers results in order, forwards wb=1 heads to the
// register file, retires every head with a one-cycle pulse and counts retired instructions.
module vx_csr_writeback #(
  parameter int DEPTH       = 2,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // cmt_ready depends only on the fill level; wb_valid only on the head entry.
  input  logic                        cmt_valid,
  output logic                        cmt_ready,
  input  logic [NW_BITS-1:0]          cmt_wid,
  input  logic [NUM_THREADS-1:0]      cmt_tmask,
  input  logic [31:0]                 cmt_pc,
  input  logic [NR_BITS-1:0]          cmt_rd,
  input  logic                        cmt_wb,
  input  logic [NUM_THREADS*32-1:0]   cmt_data,
  input  logic                        cmt_eop,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [NW_BITS-1:0]          wb_wid,
  output logic [NUM_THREADS-1:0]      wb_tmask,
  output logic [31:0]                 wb_pc,
  output logic [NR_BITS-1:0]          wb_rd,
  output logic [NUM_THREADS*32-1:0]   wb_data,
  output logic                        retire_valid,
  output logic [NW_BITS-1:0]          retire_wid,
  output logic [NR_BITS-1:0]          retire_rd,
  output logic                        retire_wb,
  output logic [63:0]                 instret,
  output logic                        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NW_BITS-1:0]        wid_q   [DEPTH];
  logic [NUM_THREADS-1:0]    tmask_q [DEPTH];
  logic [31:0]               pc_q    [DEPTH];
  logic [NR_BITS-1:0]        rd_q    [DEPTH];
  logic                      wbf_q   [DEPTH];
  logic [NUM_THREADS*32-1:0] data_q  [DEPTH];
  logic                      eop_q   [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      instret_q, instret_d;

  logic head_valid;
  logic head_wb;
  logic push;
  logic pop;

  assign head_valid = (count_q != '0);
  assign head_wb    = wbf_q[rptr_q];

  assign cmt_ready  = (count_q != CNT_W'(DEPTH));
  assign push       = cmt_valid && cmt_ready;
  // A wb=0 head leaves on its first cycle at the head; a wb=1 head waits for the regfile.
  assign pop        = !reset && head_valid && (!head_wb || wb_ready);

  assign wb_valid     = !reset && head_valid && head_wb;
  assign wb_wid       = wid_q[rptr_q];
  assign wb_tmask     = tmask_q[rptr_q];
  assign wb_pc        = pc_q[rptr_q];
  assign wb_rd        = rd_q[rptr_q];
  assign wb_data      = data_q[rptr_q];

  assign retire_valid = pop;
  assign retire_wid   = wid_q[rptr_q];
  assign retire_rd    = rd_q[rptr_q];
  assign retire_wb    = head_wb;

  assign instret      = instret_q;
  assign empty        = !head_valid;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    instret_d = instret_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (pop && eop_q[rptr_q]) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      instret_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      instret_q <= instret_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      wid_q[wptr_q]   <= cmt_wid;
      tmask_q[wptr_q] <= cmt_tmask;
      pc_q[wptr_q]    <= cmt_pc;
      rd_q[wptr_q]    <= cmt_rd;
      wbf_q[wptr_q]   <= cmt_wb;
      data_q[wptr_q]  <= cmt_data;
      eop_q[wptr_q]   <= cmt_eop;
    end
  end

endmodule

// File: tb/tb_vx_csr_writeback.sv
// Bench for vx_csr_writeback: directed scenarios plus a random stream, checked by a
// negedge monitor against an in-order queue model of the commit buffer.
module tb_vx_csr_writeback;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [1:0]   wid;
    logic [3:0]   tmask;
    logic [31:0]  pc;
    logic [5:0]   rd;
    logic         wb;
    logic [127:0] data;
    logic         eop;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmt_valid = 1'b0;
  logic         cmt_ready;
  logic [1:0]   cmt_wid = '0;
  logic [3:0]   cmt_tmask = '0;
  logic [31:0]  cmt_pc = '0;
  logic [5:0]   cmt_rd = '0;
  logic         cmt_wb = 1'b0;
  logic [127:0] cmt_data = '0;
  logic         cmt_eop = 1'b0;
  logic         wb_valid;
  logic         wb_ready = 1'b0;
  logic [1:0]   wb_wid;
  logic [3:0]   wb_tmask;
  logic [31:0]  wb_pc;
  logic [5:0]   wb_rd;
  logic [127:0] wb_data;
  logic         retire_valid;
  logic [1:0]   retire_wid;
  logic [5:0]   retire_rd;
  logic         retire_wb;
  logic [63:0]  instret;
  logic         empty;

  vx_csr_writeback #(.DEPTH(DEPTH), .NUM_THREADS(4), .NW_BITS(2), .NR_BITS(6)) dut (
    .clk(clk), .reset(reset),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_wid(cmt_wid), .cmt_tmask(cmt_tmask),
    .cmt_pc(cmt_pc), .cmt_rd(cmt_rd), .cmt_wb(cmt_wb), .cmt_data(cmt_data), .cmt_eop(cmt_eop),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid), .wb_tmask(wb_tmask),
    .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data),
    .retire_valid(retire_valid), .retire_wid(retire_wid), .retire_rd(retire_rd),
    .retire_wb(retire_wb), .instret(instret), .empty(empty)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_retire = 0;
  ent_t exp_q[$];
  logic [63:0] exp_instret = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  ent_t h;
  logic acc;
  logic exp_ret;

  always @(negedge clk) begin
    if (reset) begin
      chk("retire_in_reset", {127'd0, retire_valid}, 128'd0);
      exp_q.delete();
      exp_instret = '0;
    end else begin
      acc = cmt_valid && (exp_q.size() != DEPTH);
      chk("instret", {64'd0, instret}, {64'd0, exp_instret});
      chk("empty", {127'd0, empty}, {127'd0, exp_q.size() == 0});
      chk("cmt_ready", {127'd0, cmt_ready}, {127'd0, exp_q.size() != DEPTH});
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        chk("wb_valid", {127'd0, wb_valid}, {127'd0, h.wb});
        if (h.wb) begin
          chk("wb_hdr", {84'd0, wb_wid, wb_tmask, wb_pc, wb_rd}, {84'd0, h.wid, h.tmask, h.pc, h.rd});
          chk("wb_data", wb_data, h.data);
        end
        exp_ret = !h.wb || wb_ready;
      end else begin
        chk("wb_valid_idle", {127'd0, wb_valid}, 128'd0);
        exp_ret = 1'b0;
      end
      chk("retire_valid", {127'd0, retire_valid}, {127'd0, exp_ret});
      if (retire_valid) n_retire++;
      if (exp_ret) begin
        h = exp_q.pop_front();
        chk("retire_fields", {119'd0, retire_wid, retire_rd, retire_wb}, {119'd0, h.wid, h.rd, h.wb});
        if (h.eop) exp_instret = exp_instret + 64'd1;
      end
      if (acc) exp_q.push_back({cmt_wid, cmt_tmask, cmt_pc, cmt_rd, cmt_wb, cmt_data, cmt_eop});
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic drive(input ent_t e);
    cmt_wid = e.wid; cmt_tmask = e.tmask; cmt_pc = e.pc; cmt_rd = e.rd;
    cmt_wb = e.wb; cmt_data = e.data; cmt_eop = e.eop;
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.wid   = 2'($urandom_range(0, 3));
    e.tmask = 4'($urandom_range(0, 15));
    e.pc    = $urandom;
    e.rd    = 6'($urandom_range(0, 63));
    e.wb    = 1'($urandom_range(0, 1));
    e.data  = {$urandom, $urandom, $urandom, $urandom};
    e.eop   = 1'($urandom_range(0, 1));
    return e;
  endfunction

  function automatic ent_t mk(input logic [1:0] wid, input logic [5:0] rd, input logic wb,
                              input logic eop, input logic [127:0] data);
    ent_t e;
    e.wid = wid; e.tmask = 4'hF; e.pc = 32'h8000_0000 + {26'd0, rd}; e.rd = rd;
    e.wb = wb; e.data = data; e.eop = eop;
    return e;
  endfunction

  task automatic push_entry(input ent_t e);
    int   waited = 0;
    logic took = 1'b0;
    drive(e);
    cmt_valid = 1'b1;
    while (!took && waited < 200) begin
      @(negedge clk);
      took = cmt_ready;
      @(posedge clk); #1;
      waited++;
    end
    cmt_valid = 1'b0;
    if (!took) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmt_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    cmt_valid = 1'b0;
    wb_ready = 1'b1;
    while (!(empty && exp_q.size() == 0) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("drain_empty", {127'd0, empty}, 128'd1);
  endtask

  function automatic logic [127:0] pat(input int i);
    logic [31:0] w;
    w = 32'hA5A5_0000 + i;
    return {w, w, w, w};
  endfunction

  // ---------------- stimulus ----------------
  int   r0;
  int   eop_cnt;
  int   sent;
  ent_t re;
  logic took;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset_instret", {64'd0, instret}, 128'd0);
    chk("reset_empty", {127'd0, empty}, 128'd1);
    chk("reset_ready", {127'd0, cmt_ready}, 128'd1);
    chk("reset_wb_valid", {127'd0, wb_valid}, 128'd0);

    // T1 single wb entry
    wb_ready = 1'b1;
    push_entry(mk(2'd1, 6'd5, 1'b1, 1'b1, pat(0)));
    chk("t1_wb_valid", {127'd0, wb_valid}, 128'd1);
    chk("t1_retire", {119'd0, retire_valid, retire_wid, retire_rd}, {119'd0, 1'b1, 2'd1, 6'd5});
    drain();
    chk("t1_instret", {64'd0, instret}, 128'd1);

    // T2 backpressure with three entries against a two-deep buffer
    do_reset();
    wb_ready = 1'b0;
    r0 = n_retire;
    fork
      begin
        for (int i = 0; i < 3; i++) push_entry(mk(2'(i), 6'(10 + i), 1'b1, 1'b1, pat(i)));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("t2_full_ready", {127'd0, cmt_ready}, 128'd0);
        for (int c = 0; c < 10; c++) begin
          chk("t2_stall_data", wb_data, pat(0));
          @(posedge clk); #1;
        end
        wb_ready = 1'b1;
      end
    join
    drain();
    chk("t2_retires", 128'(n_retire - r0), 128'd3);

    // T3 wb=0 entry between two wb=1 entries
    do_reset();
    wb_ready = 1'b1;
    push_entry(mk(2'd0, 6'd1, 1'b1, 1'b1, pat(20)));
    push_entry(mk(2'd2, 6'd2, 1'b0, 1'b1, pat(21)));
    push_entry(mk(2'd3, 6'd3, 1'b1, 1'b1, pat(22)));
    drain();
    chk("t3_instret", {64'd0, instret}, 128'd3);

    // T4 multi-packet instruction counts once
    do_reset();
    r0 = n_retire;
    push_entry(mk(2'd1, 6'd7, 1'b1, 1'b0, pat(30)));
    push_entry(mk(2'd1, 6'd7, 1'b1, 1'b1, pat(31)));
    drain();
    chk("t4_retires", 128'(n_retire - r0), 128'd2);
    chk("t4_instret", {64'd0, instret}, 128'd1);

    // T5 reset while full and stalled
    do_reset();
    wb_ready = 1'b0;
    push_entry(mk(2'd2, 6'd8, 1'b1, 1'b1, pat(40)));
    push_entry(mk(2'd3, 6'd9, 1'b1, 1'b1, pat(41)));
    chk("t5_full", {127'd0, cmt_ready}, 128'd0);
    do_reset();
    chk("t5_empty", {127'd0, empty}, 128'd1);
    chk("t5_ready", {127'd0, cmt_ready}, 128'd1);
    chk("t5_instret", {64'd0, instret}, 128'd0);
    chk("t5_no_retire", {127'd0, retire_valid}, 128'd0);
    wb_ready = 1'b1;
    push_entry(mk(2'd1, 6'd5, 1'b1, 1'b1, pat(50)));
    chk("t5_retire", {119'd0, retire_valid, retire_wid, retire_rd}, {119'd0, 1'b1, 2'd1, 6'd5});
    drain();
    chk("t5_instret_after", {64'd0, instret}, 128'd1);

    // T6 random stream with random regfile backpressure
    do_reset();
    eop_cnt = 0;
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      re = rand_ent();
      drive(re);
      cmt_valid = ($urandom_range(0, 3) != 0);
      wb_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      took = cmt_valid && cmt_ready;
      @(posedge clk); #1;
      if (took) begin
        sent++;
        if (re.eop) eop_cnt++;
      end
    end
    chk("t6_sent", 128'(sent), 128'd1000);
    drain();
    chk("t6_instret", {64'd0, instret}, 128'(eop_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected completion before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
